// File: rtl/ethernet_tx_framer.sv
// RMII/MII transmit framer: preamble, SFD, MAC header, streamed payload, optional pad, CRC-32 FCS, IFG.
// Build macro TX_PAD_EN adds zero padding up to a 46-byte minimum payload.
module ethernet_tx_framer #(
  parameter int N = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         tx_start_i,
  input  logic [47:0]  dst_mac_i,
  input  logic [47:0]  src_mac_i,
  input  logic [15:0]  ethertype_i,
  input  logic [7:0]   axiid_i,
  input  logic         axiiv_i,
  input  logic         axiilast_i,
  output logic         axiordy_o,
  output logic         eth_txen_o,
  output logic [N-1:0] eth_txd_o,
  output logic         tx_busy_o,
  output logic         tx_done_o,
  output logic         tx_err_o
);
  localparam int          CPB       = 8 / N;
  localparam logic [2:0]  LAST_SLOT = 3'(CPB - 1);
  localparam logic [10:0] IFG_LAST  = 11'(12 * CPB - 1);
  localparam logic [10:0] MAX_PAY   = 11'd1500;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
`ifdef TX_PAD_EN
    S_PAD  = 3'd4,
`endif
    S_FCS  = 3'd5,
    S_IFG  = 3'd6
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    slot_q, slot_d;
  logic [10:0]   idx_q, idx_d;
  logic [10:0]   plen_q, plen_d;
  logic          last_q, last_d;
  logic          good_q, good_d;
  logic [31:0]   sh_q, sh_d;
  logic [111:0]  hdr_q, hdr_d;
  logic [31:0]   crc_q, crc_d;
  logic          txen_q, txen_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          rdy_q, rdy_d;
  logic          eob_s, take_s, fcs_s;
  logic [31:0]   crc_nx_s;

  // Reflected CRC-32 advanced over N bits, bit 0 first.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [N-1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < N; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // Next-state, datapath and pulse generation for the framer FSM.
  always_comb begin
    state_d  = state_q;
    slot_d   = slot_q;
    idx_d    = idx_q;
    plen_d   = plen_q;
    last_d   = last_q;
    good_d   = good_q;
    sh_d     = sh_q;
    hdr_d    = hdr_q;
    crc_d    = crc_q;
    txen_d   = txen_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    rdy_d    = 1'b0;
    take_s   = 1'b0;
    fcs_s    = 1'b0;
    eob_s    = (slot_q == LAST_SLOT);
    crc_nx_s = crc_step(crc_q, sh_q[N-1:0]);
    if (txen_q) begin
      sh_d   = sh_q >> N;
      slot_d = eob_s ? 3'd0 : slot_q + 3'd1;
    end else begin
      slot_d = 3'd0;
    end

    case (state_q)
      S_IDLE: begin
        if (tx_start_i) begin
          state_d = S_PRE;
          hdr_d   = {dst_mac_i, src_mac_i, ethertype_i};
          sh_d    = 32'h0000_0055;
          idx_d   = 11'd0;
          plen_d  = 11'd0;
          last_d  = 1'b0;
          good_d  = 1'b1;
          crc_d   = 32'hFFFF_FFFF;
          txen_d  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PRE: begin
        if (eob_s && idx_q == 11'd7) begin
          state_d = S_HDR;
          idx_d   = 11'd0;
          sh_d    = {24'd0, hdr_q[111:104]};
          hdr_d   = hdr_q << 8;
        end else if (eob_s) begin
          idx_d = idx_q + 11'd1;
          sh_d  = (idx_q == 11'd6) ? 32'h0000_00D5 : 32'h0000_0055;
        end else begin
          idx_d = idx_q;
        end
      end
      S_HDR: begin
        crc_d = crc_nx_s;
        if (eob_s && idx_q == 11'd13) begin
          take_s = 1'b1;
        end else if (eob_s) begin
          idx_d = idx_q + 11'd1;
          sh_d  = {24'd0, hdr_q[111:104]};
          hdr_d = hdr_q << 8;
        end else begin
          idx_d = idx_q;
        end
      end
      S_PAY: begin
        crc_d = crc_nx_s;
        if (eob_s && !last_q) begin
          take_s = 1'b1;
        end else if (eob_s) begin
`ifdef TX_PAD_EN
          if (plen_q < 11'd46) begin
            state_d = S_PAD;
            sh_d    = 32'd0;
          end else begin
            fcs_s = 1'b1;
          end
`else
          fcs_s = 1'b1;
`endif
        end else begin
          fcs_s = 1'b0;
        end
      end
`ifdef TX_PAD_EN
      S_PAD: begin
        crc_d = crc_nx_s;
        if (eob_s && plen_q == 11'd45) begin
          fcs_s = 1'b1;
        end else if (eob_s) begin
          plen_d = plen_q + 11'd1;
        end else begin
          plen_d = plen_q;
        end
      end
`endif
      S_FCS: begin
        if (eob_s && idx_q == 11'd3) begin
          state_d = S_IFG;
          txen_d  = 1'b0;
          sh_d    = 32'd0;
          idx_d   = 11'd0;
        end else if (eob_s) begin
          idx_d = idx_q + 11'd1;
        end else begin
          idx_d = idx_q;
        end
      end
      S_IFG: begin
        done_d = good_q && (idx_q == IFG_LAST - 11'd1);
        if (idx_q == IFG_LAST) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          idx_d   = 11'd0;
        end else begin
          idx_d = idx_q + 11'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        txen_d  = 1'b0;
        busy_d  = 1'b0;
        sh_d    = 32'd0;
        idx_d   = 11'd0;
      end
    endcase

    // An empty or over-long payload aborts into the IFG without a done pulse.
    case ({take_s, fcs_s})
      2'b10: begin
        if (!axiiv_i || (plen_q == MAX_PAY - 11'd1 && !axiilast_i)) begin
          state_d = S_IFG;
          txen_d  = 1'b0;
          err_d   = 1'b1;
          good_d  = 1'b0;
          sh_d    = 32'd0;
          idx_d   = 11'd0;
          slot_d  = 3'd0;
        end else begin
          state_d = S_PAY;
          sh_d    = {24'd0, axiid_i};
          plen_d  = plen_q + 11'd1;
          last_d  = axiilast_i;
        end
      end
      2'b01: begin
        state_d = S_FCS;
        sh_d    = ~crc_nx_s;
        idx_d   = 11'd0;
      end
      default: begin
        take_s = 1'b0;
      end
    endcase

    rdy_d = (slot_d == LAST_SLOT) &&
            ((state_d == S_HDR && idx_d == 11'd13) || (state_d == S_PAY && !last_d));
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      slot_q  <= 3'd0;
      idx_q   <= 11'd0;
      plen_q  <= 11'd0;
      last_q  <= 1'b0;
      good_q  <= 1'b0;
      sh_q    <= 32'd0;
      hdr_q   <= 112'd0;
      crc_q   <= 32'hFFFF_FFFF;
      txen_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      idx_q   <= idx_d;
      plen_q  <= plen_d;
      last_q  <= last_d;
      good_q  <= good_d;
      sh_q    <= sh_d;
      hdr_q   <= hdr_d;
      crc_q   <= crc_d;
      txen_q  <= txen_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end

  assign axiordy_o  = rdy_q;
  assign eth_txen_o = txen_q;
  assign eth_txd_o  = sh_q[N-1:0];
  assign tx_busy_o  = busy_q;
  assign tx_done_o  = done_q;
  assign tx_err_o   = err_q;
endmodule
